// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for the hazard controller
package pipeline_pkg;

    typedef logic [3:0] reg_addr_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        ERROR    = 2'd3
    } riesgo_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/deteccion_load_use.sv
// rtl/deteccion_load_use.sv - combinational load-use match between EXE load and ID sources
module deteccion_load_use
    import pipeline_pkg::*;
(
    input  reg_addr_t reg1_id_i,
    input  reg_addr_t reg2_id_i,
    input  reg_addr_t st_src_id_i,
    input  logic      uses_reg1_id_i,
    input  logic      uses_reg2_id_i,
    input  logic      uses_st_id_i,
    input  reg_addr_t dest_exe_i,
    input  logic      mem_r_en_exe_i,
    output logic      lu_o
);

    logic hit_reg1;
    logic hit_reg2;
    logic hit_st;

    // Register 0 is a real destination here, so no zero-register exemption.
    assign hit_reg1 = uses_reg1_id_i && (reg1_id_i   == dest_exe_i);
    assign hit_reg2 = uses_reg2_id_i && (reg2_id_i   == dest_exe_i);
    assign hit_st   = uses_st_id_i   && (st_src_id_i == dest_exe_i);

    assign lu_o = mem_r_en_exe_i && (hit_reg1 || hit_reg2 || hit_st);

endmodule

// File: rtl/unidad_control_riesgos.sv
// rtl/unidad_control_riesgos.sv - pipeline stall/flush/freeze controller (load-use, branch, memory wait, debug halt)
// Optional saturating perf counters enabled by HAZARD_PERF_EN.
module unidad_control_riesgos
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int WAIT_W      = 8
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W      = 16
`endif
) (
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t reg1_ID,
    input  reg_addr_t reg2_ID,
    input  reg_addr_t ST_src_ID,
    input  logic      uses_reg1_ID,
    input  logic      uses_reg2_ID,
    input  logic      uses_ST_ID,
    input  reg_addr_t dest_EXE,
    input  logic      MEM_R_EN_EXE,
    input  logic      branch_taken_EXE,
    input  logic      mem_req_MEM,
    input  logic      mem_ready_MEM,
    input  logic      dbg_halt_req,
    output logic      PC_stall,
    output logic      IF_ID_stall,
    output logic      IF_ID_flush,
    output logic      ID_EXE_flush,
    output logic      freeze,
    output logic      mem_error,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
`endif
    output logic      dbg_halted
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    riesgo_state_t     state_q;
    riesgo_state_t     state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              lu;

    deteccion_load_use u_deteccion_load_use (
        .reg1_id_i      (reg1_ID),
        .reg2_id_i      (reg2_ID),
        .st_src_id_i    (ST_src_ID),
        .uses_reg1_id_i (uses_reg1_ID),
        .uses_reg2_id_i (uses_reg2_ID),
        .uses_st_id_i   (uses_ST_ID),
        .dest_exe_i     (dest_EXE),
        .mem_r_en_exe_i (MEM_R_EN_EXE),
        .lu_o           (lu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EXE_flush = 1'b0;
        freeze       = 1'b0;
        mem_error    = 1'b0;
        dbg_halted   = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req_MEM && !mem_ready_MEM) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = MEM_WAIT;
                end else if (branch_taken_EXE) begin
                    IF_ID_flush  = 1'b1;
                    ID_EXE_flush = 1'b1;
                end else if (lu) begin
                    PC_stall     = 1'b1;
                    IF_ID_stall  = 1'b1;
                    ID_EXE_flush = 1'b1;
                end else if (dbg_halt_req) begin
                    state_d = HALT;
                end
            end

            MEM_WAIT: begin
                if (mem_ready_MEM) begin
                    // Release cycle: EXE was frozen, so its branch/load-use is acted on now.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (branch_taken_EXE) begin
                        IF_ID_flush  = 1'b1;
                        ID_EXE_flush = 1'b1;
                    end else if (lu) begin
                        PC_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EXE_flush = 1'b1;
                    end
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end

            HALT: begin
                freeze     = 1'b1;
                dbg_halted = 1'b1;
                if (!dbg_halt_req) begin
                    state_d = RUN;
                end
            end

            ERROR: begin
                freeze    = 1'b1;
                mem_error = 1'b1;
            end

            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((freeze || PC_stall) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (IF_ID_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/unidad_control_riesgos.md
Name: unidad_control_riesgos

Overview:
- Hazard and stall controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB) with 16 registers addressed by 4 bits.
- Works alongside the forwarding unit. It handles the cases forwarding cannot cover:
  - load-use hazards (one bubble);
  - taken-branch flush;
  - a multi-cycle data-memory wait with timeout;
  - a debug halt request.
- Drives stall, flush and freeze controls on PC, IF/ID and ID/EXE, and a global freeze of all pipeline registers.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive freeze cycles on one memory access before error; legal range 2..255.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.
- PERF_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- reg1_ID, reg2_ID  in  4  ALU source registers of the instruction in ID
- ST_src_ID  in  4  store-data source register in ID
- uses_reg1_ID, uses_reg2_ID, uses_ST_ID  in  1  the corresponding ID field is a real read
- dest_EXE  in  4  destination register of the instruction in EXE
- MEM_R_EN_EXE  in  1  instruction in EXE is a load
- branch_taken_EXE  in  1  branch resolved taken in EXE
- mem_req_MEM  in  1  MEM stage is issuing a data-memory access
- mem_ready_MEM  in  1  data memory completes the access this cycle
- dbg_halt_req  in  1  debug halt request (level)
- PC_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF/ID
- IF_ID_flush  out  1  clear IF/ID to NOP
- ID_EXE_flush  out  1  load NOP into ID/EXE
- freeze  out  1  hold every pipeline register, PC included
- mem_error  out  1  memory timeout, sticky
- dbg_halted  out  1  pipeline is halted for debug

Behaviour:
- **Reset:** asynchronous; state = RUN, wait_cnt = 0.
  - Every output is 0 while rst = 1 and in the first cycle after release, unless inputs assert a combinational condition.
- **States:** RUN, MEM_WAIT, HALT, ERROR. Outputs are Mealy: combinational from state plus inputs, zero latency.
- **Load-use hazard:** lu = MEM_R_EN_EXE & ((uses_reg1_ID & reg1_ID == dest_EXE) | (uses_reg2_ID & reg2_ID == dest_EXE) | (uses_ST_ID & ST_src_ID == dest_EXE)). No register is exempt.
- **RUN, priority highest first:**
  1. mem_req_MEM & !mem_ready_MEM: freeze = 1, all other controls 0, wait_cnt <= 1, next state MEM_WAIT.
  2. branch_taken_EXE: IF_ID_flush = 1, ID_EXE_flush = 1; lu ignored (the dependent instruction is being killed); stay in RUN.
  3. lu: PC_stall = 1, IF_ID_stall = 1, ID_EXE_flush = 1 for exactly one cycle. The load then leaves EXE, so the hazard clears on its own.
  4. dbg_halt_req: next state HALT; no controls asserted this cycle.
  5. Otherwise all outputs 0.
- **MEM_WAIT:**
  - freeze = 1 while !mem_ready_MEM.
  - mem_ready_MEM = 1: freeze = 0 that cycle, next state RUN, and the RUN priority rules 2–3 are evaluated in the same cycle.
  - !mem_ready_MEM & wait_cnt == MEM_TIMEOUT-1: next state ERROR.
  - Otherwise wait_cnt++.
  - Ready wins over timeout when both occur in the same cycle.
- **Frozen EXE:** while freeze = 1, branch_taken_EXE and lu are held by the frozen EXE stage. They are acted on in the release cycle, and no flush or stall is lost.
- **HALT:**
  - freeze = 1 and dbg_halted = 1.
  - dbg_halt_req = 0: next state RUN. freeze and dbg_halted drop in the first RUN cycle.
  - dbg_halt_req falling in the same cycle that HALT is entered still gives exactly one HALT cycle.
- **ERROR:** freeze = 1, mem_error = 1, sticky until rst; all other inputs are ignored.
- **Mutual exclusion:** flush and stall outputs are never 1 in a cycle where freeze = 1.
- **Reset mid-wait:** returns to RUN immediately and discards wait_cnt.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- **When defined,** adds outputs stall_cnt[PERF_W-1:0] and flush_cnt[PERF_W-1:0], both reset to 0 and saturating at all-ones.
  - stall_cnt increments on each cycle with freeze | PC_stall.
  - flush_cnt increments on each cycle with IF_ID_flush.
- **When undefined,** those ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef reg_addr_t (logic [3:0]);
  - typedef enum riesgo_state_t {RUN, MEM_WAIT, HALT, ERROR};
  - localparam MEM_TIMEOUT_DEFAULT = 64.
- Sub-module deteccion_load_use contains the purely combinational lu comparison. Everything else stays in the top module.

Test Plan:
- **Load-use:** load R3 in EXE (MEM_R_EN_EXE = 1, dest_EXE = 3), ID reads reg2_ID = 3 with uses_reg2_ID = 1 -> one cycle of PC_stall = IF_ID_stall = ID_EXE_flush = 1, then all 0. Repeat with uses_reg2_ID = 0 -> no stall.
- **Branch over load-use:** branch_taken_EXE = 1 with a concurrent load-use match -> IF_ID_flush = ID_EXE_flush = 1, PC_stall = 0.
- **Memory wait:** mem_req_MEM = 1, ready arrives 3 cycles later -> freeze = 1 for 3 cycles, 0 in the ready cycle, mem_error = 0.
- **Timeout:** MEM_TIMEOUT = 4, ready never arrives -> freeze for 4 cycles, mem_error = 1 from cycle 5 and held. Asserting rst clears it asynchronously.
- **Debug halt:** dbg_halt_req held 5 cycles -> dbg_halted = freeze = 1 starting the cycle after the request, and cleared the cycle after the request drops.
- **Perf counters (HAZARD_PERF_EN):** after the load-use and memory-wait scenarios, stall_cnt = 4 and flush_cnt = 0. Force 2^PERF_W + 3 stall cycles -> stall_cnt saturates at all-ones.
